fft_stream_host: RTL and testbench
==================================

Name: fft_stream_host

Overview:
Host-side counterpart of the FFT AXI-style sample bridge. Buffers host-supplied samples in a small FIFO, streams one frame of N samples into the bridge over the AR valid/ready channel, then accepts the N result words returned over the AW valid/ready channel. Results are presented to the host as indexed, registered pulses. Sits between the test/host logic and the FFT bridge.

Parameters:
DATA_WIDTH, 32, width of sample and result words
FIFO_DEPTH, 16, transmit FIFO depth in words; power of 2, minimum 2
TIMEOUT_CYCLES, 1024, watchdog limit; used only with FFT_HOST_TIMEOUT_EN

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_push  in  1  host write strobe into the transmit FIFO
i_push_data  in  DATA_WIDTH  sample to buffer
o_full  out  1  FIFO full; a push while full is dropped
i_start  in  1  start a frame; sampled only in IDLE
i_samples_number  in  12  frame length N; latched on accepted start
o_ARVALID  out  1  sample valid towards bridge
i_ARREADY  in  1  bridge accepts sample
o_ARDATA  out  DATA_WIDTH  sample = FIFO head
i_AWVALID  in  1  bridge result valid
o_AWREADY  out  1  host ready for result
i_AWDATA  in  DATA_WIDTH  result word
o_res_valid  out  1  one-cycle pulse per received result
o_res_data  out  DATA_WIDTH  received result
o_res_index  out  12  index of received result, 0..N-1
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at frame completion
o_timeout  out  1  watchdog pulse (0 when feature is compiled out)

Behaviour:
- Reset: all outputs 0, FIFO empty, tx/rx counters 0, latched N = 0, state IDLE. Reset mid-frame aborts the frame and discards FIFO contents.
- FIFO: first-word fall-through. A push into an empty FIFO is visible on o_ARDATA the next cycle.
- Push is accepted iff i_push && !o_full; o_full is registered from the count. Pop occurs on an AR beat.
- Push and pop in the same cycle: count is unchanged and both take effect.
- Pushes are accepted in every state, so the host can prefill the FIFO before start.
- A beat occurs when valid && ready are both high in the same cycle, on either channel.
- FSM states:
  - IDLE: on i_start with i_samples_number != 0, latch N, clear counters, go to SEND. A start with N == 0 is ignored. i_start outside IDLE is ignored.
  - SEND: o_ARVALID = !fifo_empty. Once o_ARVALID is asserted it must stay high with o_ARDATA stable until the beat. Each AR beat pops the FIFO and increments tx_cnt. On the beat with tx_cnt == N-1, clear tx_cnt and go to RECV. An empty FIFO stalls the frame with no error.
  - RECV: o_AWREADY = 1. Each AW beat registers o_res_data = i_AWDATA and o_res_index = rx_cnt, pulses o_res_valid the next cycle, and increments rx_cnt. On the beat with rx_cnt == N-1, go to DONE.
  - DONE: o_done = 1 for one cycle, then go to IDLE.
- o_ARVALID and o_AWREADY are combinational from state and FIFO empty. All o_res_* outputs, o_done and o_timeout are registered.
- Counters are 12 bits; N = 4095 is the maximum frame length. No wrap occurs within a frame.
- i_AWVALID outside RECV is ignored, and o_AWREADY = 0. i_ARREADY outside SEND is ignored.
- Changes to i_samples_number after start have no effect until the next start.

Optional Feature:
FFT_HOST_TIMEOUT_EN: when defined, a watchdog counter clears on every beat and on entry to SEND or RECV, and increments each cycle spent in SEND or RECV. On reaching TIMEOUT_CYCLES, pulse o_timeout for one cycle, go to IDLE, clear counters, and flush the FIFO. When undefined, no watchdog logic is built, o_timeout is tied to 0, and the block waits indefinitely.

Test Plan:
- Prefill 8 samples 0x10..0x17, start with N=8, hold i_ARREADY=1 -> eight AR beats on consecutive cycles carrying 0x10..0x17, then o_AWREADY=1 in RECV.
- In RECV, drive 8 AW beats of 0xA0..0xA7 with i_AWVALID toggling every other cycle -> o_res_valid pulses with indices 0..7 and matching data, then one o_done pulse, then o_busy=0.
- Hold i_ARREADY=0 for 5 cycles with the FIFO non-empty -> o_ARVALID stays 1, o_ARDATA is stable, no pop; on release the beat occurs.
- Push 17 words into the 16-deep FIFO -> o_full=1 after the 16th push, the 17th word is dropped, and 16 words stream out in order.
- Start with N=0 -> no state change. Assert i_rstn=0 mid-SEND after 3 beats -> all outputs 0, FIFO empty, state IDLE.
- With FFT_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall in RECV with i_AWVALID=0 -> o_timeout pulses once at cycle 16, the block returns to IDLE, and no o_done occurs.

Source files
------------

// File: rtl/fft_stream_host.sv
// Purpose     : host side of the FFT sample bridge; buffers samples, sends one frame of N over AR, collects N results over AW.
// Latency     : a push into an empty FIFO is on o_ARDATA next cycle; a result is on o_res_* one cycle after its AW beat.
// Backpressure: o_full refuses (drops) pushes; AR waits on i_ARREADY with data held; AW is accepted only in RECV.
//
// Ports: i_clk/i_rstn clock and async active-low reset; i_push/i_push_data/o_full host FIFO write;
//        i_start/i_samples_number frame start and length; o_ARVALID/i_ARREADY/o_ARDATA sample stream out;
//        i_AWVALID/o_AWREADY/i_AWDATA result stream in; o_res_valid/o_res_data/o_res_index result pulses;
//        o_busy/o_done/o_timeout status.
// Optional feature macro: FFT_HOST_TIMEOUT_EN builds a watchdog on SEND/RECV that aborts the frame.
module fft_stream_host #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_full,
  input  logic                  i_start,
  input  logic [11:0]           i_samples_number,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_AWVALID,
  output logic                  o_AWREADY,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_res_valid,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic [11:0]           o_res_index,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fft_stream_host: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  state_t                state;
  logic [11:0]           n_q;
  logic [11:0]           tx_cnt;
  logic [11:0]           rx_cnt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nxt;

  logic fifo_empty;
  logic push_ok;
  logic ar_beat;
  logic aw_beat;
  logic flush;

  assign fifo_empty = (count == '0);
  assign push_ok    = i_push && !o_full;
  // Head of a FWFT FIFO only moves on a pop, so o_ARDATA is stable while AR is stalled.
  assign o_ARVALID  = (state == S_SEND) && !fifo_empty;
  assign o_AWREADY  = (state == S_RECV);
  assign o_ARDATA   = mem[rd_ptr];
  assign ar_beat    = o_ARVALID && i_ARREADY;
  assign aw_beat    = o_AWREADY && i_AWVALID;
  assign o_busy     = (state != S_IDLE);

`ifdef FFT_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_fire;

  // A beat in the same cycle restarts the count rather than firing.
  assign wd_fire = ((state == S_SEND) || (state == S_RECV)) && !ar_beat && !aw_beat &&
                   (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign flush   = wd_fire;
`else
  assign flush     = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    if (push_ok && !ar_beat)      count_nxt = count + 1'b1;
    else if (!push_ok && ar_beat) count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_full <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (ar_beat) rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      o_full <= (count_nxt == (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      n_q         <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_index <= '0;
      o_done      <= 1'b0;
`ifdef FFT_HOST_TIMEOUT_EN
      o_timeout   <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      o_res_valid <= 1'b0;
      o_done      <= 1'b0;
      if (aw_beat) begin
        o_res_valid <= 1'b1;
        o_res_data  <= i_AWDATA;
        o_res_index <= rx_cnt;
      end
      case (state)
        S_IDLE: begin
          if (i_start && (i_samples_number != 12'd0)) begin
            n_q    <= i_samples_number;
            tx_cnt <= '0;
            rx_cnt <= '0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (ar_beat) begin
            if (tx_cnt == n_q - 12'd1) begin
              tx_cnt <= '0;
              state  <= S_RECV;
            end else begin
              tx_cnt <= tx_cnt + 12'd1;
            end
          end
        end
        S_RECV: begin
          if (aw_beat) begin
            rx_cnt <= rx_cnt + 12'd1;
            if (rx_cnt == n_q - 12'd1) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef FFT_HOST_TIMEOUT_EN
      o_timeout <= 1'b0;
      // Held at zero outside SEND/RECV, so entering either state starts from zero.
      if ((state == S_SEND) || (state == S_RECV)) begin
        if (ar_beat || aw_beat) begin
          wd_cnt <= '0;
        end else if (wd_fire) begin
          o_timeout <= 1'b1;
          state     <= S_IDLE;
          tx_cnt    <= '0;
          rx_cnt    <= '0;
          wd_cnt    <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft_stream_host.sv
module tb_fft_stream_host;

  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_push = 1'b0;
  logic [DW-1:0] i_push_data = '0;
  logic          o_full;
  logic          i_start = 1'b0;
  logic [11:0]   i_samples_number = '0;
  logic          o_ARVALID;
  logic          i_ARREADY = 1'b0;
  logic [DW-1:0] o_ARDATA;
  logic          i_AWVALID = 1'b0;
  logic          o_AWREADY;
  logic [DW-1:0] i_AWDATA = '0;
  logic          o_res_valid;
  logic [DW-1:0] o_res_data;
  logic [11:0]   o_res_index;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;

  fft_stream_host #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_push(i_push), .i_push_data(i_push_data), .o_full(o_full),
    .i_start(i_start), .i_samples_number(i_samples_number),
    .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY), .o_ARDATA(o_ARDATA),
    .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY), .i_AWDATA(i_AWDATA),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_index(o_res_index),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] ar_q[$];
  logic [63:0] res_q[$];

  int cyc = 0;
  int ar_beats = 0, first_ar_cyc = 0, last_ar_cyc = 0;
  int res_cnt = 0, done_cnt = 0, to_cnt = 0;
  int aw_rise_cyc = 0, to_cyc = 0;
  logic awrdy_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit accepted);
    i_push = 1'b1;
    i_push_data = d;
    if (accepted) ar_q.push_back(64'(d));
    tick();
    i_push = 1'b0;
  endtask

  task automatic start_frame(input logic [11:0] n);
    i_start = 1'b1;
    i_samples_number = n;
    tick();
    i_start = 1'b0;
    i_samples_number = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_awready(input string tag);
    for (int i = 0; i < 300 && !o_AWREADY; i++) @(negedge i_clk);
    chk(tag, 64'(o_AWREADY), 64'd1);
    tick();
  endtask

  task automatic aw_frame(input int n, input logic [DW-1:0] base, input bit toggle);
    for (int k = 0; k < n; k++) begin
      i_AWVALID = 1'b1;
      i_AWDATA = base + DW'(k);
      res_q.push_back({20'(k), 12'd0, 32'(base + DW'(k))});
      tick();
      if (toggle) begin
        i_AWVALID = 1'b0;
        tick();
      end
    end
    i_AWVALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 500 && o_busy; i++) @(negedge i_clk);
    chk(tag, 64'(o_busy), 64'd0);
    tick();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rstn) begin
      if (o_ARVALID && i_ARREADY) begin
        if (ar_beats == 0) first_ar_cyc = cyc;
        last_ar_cyc = cyc;
        ar_beats++;
        if (ar_q.size() == 0) chk("ar_unexpected", 64'(o_ARDATA), 64'hdead);
        else chk("ar_data", 64'(o_ARDATA), ar_q.pop_front());
      end
      if (o_res_valid) begin
        res_cnt++;
        if (res_q.size() == 0) chk("res_unexpected", 64'(o_res_data), 64'hdead);
        else chk("res_idx_data", {20'(o_res_index), 12'd0, 32'(o_res_data)}, res_q.pop_front());
      end
      if (o_done) done_cnt++;
      if (o_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (o_AWREADY && !awrdy_prev) aw_rise_cyc = cyc;
    end
    awrdy_prev = o_AWREADY;
  end

  initial begin
    // Reset state
    #12;
    chk("reset_outs", {57'd0, o_full, o_ARVALID, o_AWREADY, o_res_valid, o_busy, o_done, o_timeout}, 64'd0);
    chk("reset_res", {20'(o_res_index), 12'd0, 32'(o_res_data)}, 64'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    tick();

    // A: prefilled frame of 8, continuous AR, toggling AW
    for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i), 1'b1);
    i_ARREADY = 1'b1;
    ar_beats = 0;
    start_frame(12'd8);
    wait_awready("a_awready");
    chk("a_ar_beats", 64'(ar_beats), 64'd8);
    chk("a_ar_consecutive", 64'(last_ar_cyc - first_ar_cyc), 64'd7);
    chk("a_arvalid_in_recv", 64'(o_ARVALID), 64'd0);
    res_cnt = 0;
    done_cnt = 0;
    aw_frame(8, 32'hA0, 1'b1);
    wait_idle("a_idle");
    chk("a_res_cnt", 64'(res_cnt), 64'd8);
    chk("a_done_cnt", 64'(done_cnt), 64'd1);
    chk("a_q_empty", 64'(ar_q.size() + res_q.size()), 64'd0);

    // B: AR stall with data held stable
    for (int i = 0; i < 4; i++) push_word(DW'(32'h20 + i), 1'b1);
    i_ARREADY = 1'b0;
    ar_beats = 0;
    start_frame(12'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("b_stall_valid", 64'(o_ARVALID), 64'd1);
      chk("b_stall_data", 64'(o_ARDATA), 64'h20);
    end
    chk("b_no_pop", 64'(ar_beats), 64'd0);
    tick();
    i_ARREADY = 1'b1;
    wait_awready("b_awready");
    chk("b_ar_beats", 64'(ar_beats), 64'd4);
    done_cnt = 0;
    aw_frame(4, 32'h5000, 1'b0);
    wait_idle("b_idle");
    chk("b_done_cnt", 64'(done_cnt), 64'd1);

    // C: overfill the 16-deep FIFO
    for (int i = 0; i < 15; i++) push_word(DW'(32'h100 + i), 1'b1);
    chk("c_not_full_15", 64'(o_full), 64'd0);
    push_word(32'h10F, 1'b1);
    chk("c_full_16", 64'(o_full), 64'd1);
    push_word(32'h1FF, 1'b0);
    ar_beats = 0;
    start_frame(12'd16);
    wait_awready("c_awready");
    chk("c_ar_beats", 64'(ar_beats), 64'd16);
    chk("c_not_full_after", 64'(o_full), 64'd0);
    aw_frame(16, 32'hC00, 1'b0);
    wait_idle("c_idle");
    chk("c_q_empty", 64'(ar_q.size() + res_q.size()), 64'd0);

    // D: N = 0 start is ignored; then reset mid-SEND after 3 beats
    push_word(32'h30, 1'b1);
    push_word(32'h31, 1'b1);
    i_ARREADY = 1'b0;
    start_frame(12'd0);
    tick();
    chk("d_n0_busy", 64'(o_busy), 64'd0);
    chk("d_n0_arvalid", 64'(o_ARVALID), 64'd0);
    for (int i = 2; i < 8; i++) push_word(DW'(32'h30 + i), 1'b1);
    start_frame(12'd8);
    ar_beats = 0;
    i_ARREADY = 1'b1;
    tick(); tick(); tick();
    i_ARREADY = 1'b0;
    i_rstn = 1'b0;
    #2;
    chk("d_beats_before_rst", 64'(ar_beats), 64'd3);
    chk("d_rst_outs", {57'd0, o_full, o_ARVALID, o_AWREADY, o_res_valid, o_busy, o_done, o_timeout}, 64'd0);
    ar_q.delete();
    tick();
    i_rstn = 1'b1;
    tick();
    // Empty FIFO after reset: a new frame stalls until a word is pushed.
    i_ARREADY = 1'b1;
    start_frame(12'd1);
    tick(); tick(); tick();
    chk("d_empty_stall_busy", 64'(o_busy), 64'd1);
    chk("d_empty_stall_arvalid", 64'(o_ARVALID), 64'd0);
    push_word(32'h55, 1'b1);
    wait_awready("d_awready");
    aw_frame(1, 32'h77, 1'b0);
    wait_idle("d_idle");

    // E: stall in RECV with i_AWVALID low
    push_word(32'h66, 1'b1);
    done_cnt = 0;
    to_cnt = 0;
    start_frame(12'd1);
    wait_awready("e_awready");
    for (int i = 0; i < 40; i++) tick();
`ifdef FFT_HOST_TIMEOUT_EN
    chk("e_timeout_cnt", 64'(to_cnt), 64'd1);
    chk("e_timeout_cycle", 64'(to_cyc - aw_rise_cyc), 64'd16);
    chk("e_busy", 64'(o_busy), 64'd0);
    chk("e_no_done", 64'(done_cnt), 64'd0);
`else
    chk("e_no_timeout", 64'(to_cnt), 64'd0);
    chk("e_still_waiting", 64'(o_AWREADY), 64'd1);
    chk("e_no_done", 64'(done_cnt), 64'd0);
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
